// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the uart_peer link partner.
// Both the transmitter and the receiver import this package.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_peer_rx.sv
// 8N1 receiver: synchronises the asynchronous serial line, finds the start edge,
// samples mid-bit and reports each frame as a one-cycle data or error strobe.
module uart_peer_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  logic                 sync1;
  logic                 sync2;
  logic                 line_q;
  rx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  // Flops preset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= IDLE_LVL;
      sync2  <= IDLE_LVL;
      line_q <= IDLE_LVL;
    end else begin
      sync1  <= uart_rx;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (line_q == IDLE_LVL && sync2 == START_LVL) state <= RX_START;
        end
        // Half a bit in: a line that is high again was only a glitch.
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= (sync2 == START_LVL) ? RX_DATA : RX_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {sync2, shreg[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) state <= RX_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (sync2 == STOP_LVL) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              state        <= RX_WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // A held-low break reports once, then waits for the line to recover.
        RX_WAIT_IDLE: begin
          if (sync2 == IDLE_LVL) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_peer.sv
// UART link partner for the far side of the SoC pins: 8N1 transmitter with a
// valid/ready byte port, plus an independent receiver in uart_peer_rx.
module uart_peer
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 434,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 uart_tx,
  input  logic                 uart_rx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] READY_AT = CNT_W'(CLK_DIV - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  tx_state_e            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 handshake;

  assign handshake = tx_valid && tx_ready;

  // tx_ready is raised one cycle early so it is visible in the last stop-bit
  // cycle, letting a waiting byte start the next frame with no idle gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= TX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= IDLE_LVL;
      tx_ready <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (handshake) begin
            shreg    <= tx_data;
            uart_tx  <= START_LVL;
            tx_ready <= 1'b0;
            state    <= TX_START;
          end
        end
        TX_START: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            uart_tx <= shreg[0];
            state   <= TX_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
              uart_tx <= STOP_LVL;
              state   <= TX_STOP;
            end else begin
              shreg   <= shreg >> 1;
              uart_tx <= shreg[1];
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (cnt == READY_AT) tx_ready <= 1'b1;
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (handshake) begin
              shreg    <= tx_data;
              uart_tx  <= START_LVL;
              tx_ready <= 1'b0;
              state    <= TX_START;
            end else begin
              state <= TX_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  uart_peer_rx #(
    .CLK_DIV(CLK_DIV),
    .CNT_W  (CNT_W)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_frame_err(rx_frame_err)
  );

endmodule

// File: tb/tb_uart_peer.sv
// Directed bench for uart_peer: a CLK_DIV=16 instance with switchable loopback
// and a CLK_DIV=4 instance permanently looped back.
module tb_uart_peer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       loop_en = 1'b0;
  logic       drv_rx = 1'b1;
  logic       rx_line;

  logic       uart_tx;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;

  logic       uart_tx4;
  logic       tx_valid4 = 1'b0;
  logic [7:0] tx_data4 = 8'h00;
  logic       tx_ready4;
  logic       rx_valid4;
  logic [7:0] rx_data4;
  logic       rx_frame_err4;

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_cnt4 = 0;
  int err_cnt4 = 0;
  logic prev_valid = 1'b0;
  logic [7:0] exp_b;
  logic [7:0] exp_b4;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q4[$];
  int valid_times[$];

  assign rx_line = loop_en ? uart_tx : drv_rx;

  uart_peer #(.CLK_DIV(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .uart_tx(uart_tx), .uart_rx(rx_line),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_frame_err(rx_frame_err)
  );

  uart_peer #(.CLK_DIV(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .uart_tx(uart_tx4), .uart_rx(uart_tx4),
    .tx_valid(tx_valid4), .tx_data(tx_data4), .tx_ready(tx_ready4),
    .rx_valid(rx_valid4), .rx_data(rx_data4), .rx_frame_err(rx_frame_err4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: every received byte is popped and compared against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        valid_cnt++;
        valid_times.push_back(cycle);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $error("FAIL rx_unexpected observed=%0h expected=none", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          assert (rx_data === exp_b) else begin
            fails++;
            $error("FAIL rx_data observed=%0h expected=%0h", rx_data, exp_b);
          end
        end
        tests++;
        assert (prev_valid === 1'b0) else begin
          fails++;
          $error("FAIL rx_valid_width observed=%0b expected=0", prev_valid);
        end
        tests++;
        assert (rx_frame_err === 1'b0) else begin
          fails++;
          $error("FAIL rx_both_strobes observed=%0b expected=0", rx_frame_err);
        end
      end
      if (rx_frame_err) err_cnt++;
      prev_valid = rx_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid4) begin
        valid_cnt4++;
        tests++;
        if (exp_q4.size() == 0) begin
          fails++;
          $error("FAIL rx4_unexpected observed=%0h expected=none", rx_data4);
        end else begin
          exp_b4 = exp_q4.pop_front();
          assert (rx_data4 === exp_b4) else begin
            fails++;
            $error("FAIL rx4_data observed=%0h expected=%0h", rx_data4, exp_b4);
          end
        end
      end
      if (rx_frame_err4) err_cnt4++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers a byte and returns just after the handshake edge.
  task automatic sendByte(input logic [7:0] d, input bit hold);
    int n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    while (!tx_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      tests++;
      fails++;
      $error("FAIL tx_ready_timeout observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    if (!hold) tx_valid = 1'b0;
  endtask

  // Drives one hand-built 16-cycle-per-bit frame onto the receive line.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_lvl);
    logic [9:0] frame;
    frame = {stop_lvl, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      drv_rx = frame[b];
      repeat (16) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic waitDrain(input int budget, input bit four);
    int n = 0;
    while ((four ? exp_q4.size() : exp_q.size()) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert ((four ? exp_q4.size() : exp_q.size()) == 0) else begin
      fails++;
      $error("FAIL drain_timeout observed=%0d expected=0",
             four ? exp_q4.size() : exp_q.size());
      exp_q.delete();
      exp_q4.delete();
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic       lvl;
    int v0, e0, t0;

    // Reset state
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_uart_tx", uart_tx, 1);
    checkOutput("rst_tx_ready", tx_ready, 1);
    checkOutput("rst_rx_valid", rx_valid, 0);
    checkOutput("rst_rx_err", rx_frame_err, 0);
    checkOutput("rst_rx_data", rx_data, 8'h00);

    // Waveform of one 0x55 frame, cycle by cycle
    pat = 8'h55;
    sendByte(pat, 1'b0);
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if (c <= 16) lvl = 1'b0;
      else if (c > 144) lvl = 1'b1;
      else lvl = pat[(c - 17) / 16];
      checkOutput("tx_line", uart_tx, lvl);
      checkOutput("tx_ready_frame", tx_ready, (c == 160) ? 1 : 0);
    end
    @(negedge clk);
    checkOutput("tx_line_after", uart_tx, 1);
    checkOutput("tx_ready_after", tx_ready, 1);

    // Loopback single byte
    loop_en = 1'b1;
    idle(5);
    v0 = valid_cnt;
    e0 = err_cnt;
    exp_q.push_back(8'hA5);
    sendByte(8'hA5, 1'b0);
    waitDrain(400, 1'b0);
    checkOutput("a5_pulses", valid_cnt - v0, 1);
    checkOutput("a5_err", err_cnt - e0, 0);
    checkOutput("a5_data", rx_data, 8'hA5);

    // Back-to-back with tx_valid held high
    t0 = valid_times.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    sendByte(8'h00, 1'b1);
    sendByte(8'hFF, 1'b0);
    waitDrain(800, 1'b0);
    checkOutput("b2b_pulses", valid_times.size() - t0, 2);
    if (valid_times.size() - t0 == 2)
      checkOutput("b2b_spacing", valid_times[t0+1] - valid_times[t0], 160);
    checkOutput("b2b_data", rx_data, 8'hFF);

    // Framing error followed by a 64-cycle break
    loop_en = 1'b0;
    drv_rx  = 1'b1;
    idle(20);
    v0 = valid_cnt;
    e0 = err_cnt;
    applyStimulus(8'h3C, 1'b0);
    drv_rx = 1'b0;
    idle(64);
    drv_rx = 1'b1;
    idle(40);
    checkOutput("ferr_err", err_cnt - e0, 1);
    checkOutput("ferr_valid", valid_cnt - v0, 0);
    checkOutput("ferr_hold", rx_data, 8'hFF);
    exp_q.push_back(8'h11);
    applyStimulus(8'h11, 1'b1);
    waitDrain(100, 1'b0);
    checkOutput("after_ferr_data", rx_data, 8'h11);

    // Short glitch, then a real frame 12 cycles after its falling edge
    idle(20);
    v0 = valid_cnt;
    e0 = err_cnt;
    drv_rx = 1'b0;
    idle(4);
    drv_rx = 1'b1;
    idle(8);
    exp_q.push_back(8'h5A);
    applyStimulus(8'h5A, 1'b1);
    waitDrain(100, 1'b0);
    checkOutput("glitch_valid", valid_cnt - v0, 1);
    checkOutput("glitch_err", err_cnt - e0, 0);
    checkOutput("glitch_data", rx_data, 8'h5A);

    // Reset in the middle of a looped-back frame
    loop_en = 1'b1;
    idle(20);
    v0 = valid_cnt;
    e0 = err_cnt;
    sendByte(8'h3C, 1'b0);
    idle(60);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_uart_tx", uart_tx, 1);
    checkOutput("mid_rst_tx_ready", tx_ready, 1);
    checkOutput("mid_rst_rx_valid", rx_valid, 0);
    checkOutput("mid_rst_rx_err", rx_frame_err, 0);
    checkOutput("mid_rst_rx_data", rx_data, 8'h00);
    idle(200);
    checkOutput("mid_rst_no_valid", valid_cnt - v0, 0);
    checkOutput("mid_rst_no_err", err_cnt - e0, 0);
    exp_q.push_back(8'h7E);
    sendByte(8'h7E, 1'b0);
    waitDrain(400, 1'b0);
    checkOutput("post_rst_data", rx_data, 8'h7E);

    // CLK_DIV=4 loopback corner
    @(negedge clk);
    checkOutput("div4_ready", tx_ready4, 1);
    exp_q4.push_back(8'h81);
    tx_data4  = 8'h81;
    tx_valid4 = 1'b1;
    @(posedge clk);
    #1;
    tx_valid4 = 1'b0;
    waitDrain(200, 1'b1);
    checkOutput("div4_valid", valid_cnt4, 1);
    checkOutput("div4_err", err_cnt4, 0);
    checkOutput("div4_data", rx_data4, 8'h81);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
